// File: rtl/time_set_if.sv
// time_set_if
//   Bundles the controller's button inputs, the running time/date from the
//   counters, and the display/commit outputs.
//   Commit semantics: load is a single-cycle strobe with no back-pressure;
//   load_* are stable whenever load=1 and the consumer must take them on
//   that cycle (it also clears seconds on load).
//   Modports:
//     master - drives buttons and cur_*, observes controller outputs
//     slave  - the controller itself
interface time_set_if;
    logic       btn_mode_n;
    logic       btn_inc_n;
    logic [4:0] cur_hour;
    logic [5:0] cur_min;
    logic [4:0] cur_day;
    logic [3:0] cur_month;
    logic [6:0] cur_year;
    logic       set_active;
    logic       show_date;
    logic [2:0] blink_mask;
    logic       load;
    logic [4:0] load_hour;
    logic [5:0] load_min;
    logic [4:0] load_day;
    logic [3:0] load_month;
    logic [6:0] load_year;

    modport master (
        output btn_mode_n, btn_inc_n,
        output cur_hour, cur_min, cur_day, cur_month, cur_year,
        input  set_active, show_date, blink_mask,
        input  load, load_hour, load_min, load_day, load_month, load_year
    );

    modport slave (
        input  btn_mode_n, btn_inc_n,
        input  cur_hour, cur_min, cur_day, cur_month, cur_year,
        output set_active, show_date, blink_mask,
        output load, load_hour, load_min, load_day, load_month, load_year
    );
endinterface

// File: rtl/time_set_controller.sv
// time_set_controller
//   Debounces the mode/inc push-buttons and runs the time/date edit FSM.
//   Mode steps RUN -> hour -> minute -> day -> month -> year -> COMMIT;
//   inc bumps the field being edited with wrap. COMMIT emits one load strobe
//   carrying all edited values (day clamped to the month length).
//   Ports:
//     clk          system clock
//     reset        synchronous, active-high
//     bus          time_set_if.slave (buttons, cur_*, display and load outputs)
//     dbg_state_o  current FSM state encoding (RUN=0 .. COMMIT=6)
module time_set_controller #(
    parameter int DEBOUNCE_CYCLES   = 1_000_000,
    parameter int BLINK_HALF_CYCLES = 12_500_000
) (
    input  logic       clk,
    input  logic       reset,
    time_set_if.slave  bus,
    output logic [2:0] dbg_state_o
);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BLW = $clog2(BLINK_HALF_CYCLES + 1);

    typedef enum logic [2:0] {
        S_RUN    = 3'd0,
        S_HOUR   = 3'd1,
        S_MIN    = 3'd2,
        S_DAY    = 3'd3,
        S_MONTH  = 3'd4,
        S_YEAR   = 3'd5,
        S_COMMIT = 3'd6
    } state_t;

    // Button conditioning; index 0 = mode, index 1 = inc.
    logic [1:0]     raw;
    logic [1:0]     sync0_q, sync1_q, level_q, press_q;
    logic [DBW-1:0] db_cnt_q [2];

    assign raw = {bus.btn_inc_n, bus.btn_mode_n};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync0_q <= 2'b11;
            sync1_q <= 2'b11;
            level_q <= 2'b11;
            press_q <= 2'b00;
            for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
        end else begin
            sync0_q <= raw;
            sync1_q <= sync0_q;
            press_q <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                if (sync1_q[i] == level_q[i]) begin
                    // Any sample agreeing with the held level restarts the count.
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
                    db_cnt_q[i] <= '0;
                    level_q[i]  <= sync1_q[i];
                    // Level was 1 and is flipping to 0: that is a press.
                    press_q[i]  <= level_q[i];
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + DBW'(1);
                end
            end
        end
    end

    logic mode_ev, inc_ev;
    assign mode_ev = press_q[0];
    assign inc_ev  = press_q[1];

    function automatic logic [4:0] days_in(input logic [3:0] m, input logic leap);
        case (m)
            4'd2:                      return leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   return 5'd30;
            default:                   return 5'd31;
        endcase
    endfunction

    function automatic logic is_set(input state_t s);
        return (s == S_HOUR) || (s == S_MIN) || (s == S_DAY) ||
               (s == S_MONTH) || (s == S_YEAR);
    endfunction

    state_t         state_q, state_d;
    logic [4:0]     hour_q, hour_d;
    logic [5:0]     min_q, min_d;
    logic [4:0]     day_q, day_d;
    logic [4:0]     day_load_q, day_load_d;
    logic [3:0]     month_q, month_d;
    logic [6:0]     year_q, year_d;
    logic [BLW-1:0] blink_cnt_q, blink_cnt_d;
    logic           phase_q, phase_d;
    logic           inc_ok;
    logic [4:0]     max_days;

    // Mode wins over a same-cycle inc; inc only counts inside SET_* states.
    assign inc_ok   = inc_ev && !mode_ev && is_set(state_q);
    assign max_days = days_in(month_q, (year_q[1:0] == 2'b00));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:    if (mode_ev) state_d = S_HOUR;
            S_HOUR:   if (mode_ev) state_d = S_MIN;
            S_MIN:    if (mode_ev) state_d = S_DAY;
            S_DAY:    if (mode_ev) state_d = S_MONTH;
            S_MONTH:  if (mode_ev) state_d = S_YEAR;
            S_YEAR:   if (mode_ev) state_d = S_COMMIT;
            S_COMMIT: state_d = S_RUN;
            default:  state_d = S_RUN;
        endcase
    end

    always_comb begin
        hour_d     = hour_q;
        min_d      = min_q;
        day_d      = day_q;
        day_load_d = day_load_q;
        month_d    = month_q;
        year_d     = year_q;
        if (state_q == S_RUN && mode_ev) begin
            hour_d     = bus.cur_hour;
            min_d      = bus.cur_min;
            day_d      = bus.cur_day;
            day_load_d = bus.cur_day;
            month_d    = bus.cur_month;
            year_d     = bus.cur_year;
        end else if (inc_ok) begin
            case (state_q)
                S_HOUR:  hour_d  = (hour_q >= 5'd23)  ? 5'd0 : hour_q + 5'd1;
                S_MIN:   min_d   = (min_q >= 6'd59)   ? 6'd0 : min_q + 6'd1;
                S_DAY: begin
                    day_d      = (day_q >= max_days)  ? 5'd1 : day_q + 5'd1;
                    day_load_d = day_d;
                end
                S_MONTH: month_d = (month_q >= 4'd12) ? 4'd1 : month_q + 4'd1;
                S_YEAR:  year_d  = (year_q >= 7'd99)  ? 7'd0 : year_q + 7'd1;
                default: ;
            endcase
        end
        // Month and year are final once SET_YEAR is left, so the clamped day
        // is registered on that transition and is stable throughout COMMIT.
        if (state_q == S_YEAR && mode_ev)
            day_load_d = (day_q > max_days) ? max_days : day_q;
    end

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (!is_set(state_d) || state_d != state_q || inc_ok) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (blink_cnt_q == BLW'(BLINK_HALF_CYCLES - 1)) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BLW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_RUN;
            hour_q      <= '0;
            min_q       <= '0;
            day_q       <= '0;
            day_load_q  <= '0;
            month_q     <= '0;
            year_q      <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            hour_q      <= hour_d;
            min_q       <= min_d;
            day_q       <= day_d;
            day_load_q  <= day_load_d;
            month_q     <= month_d;
            year_q      <= year_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    always_comb begin
        bus.blink_mask = 3'b000;
        case (state_q)
            S_HOUR, S_YEAR: bus.blink_mask = {phase_q, 2'b00};
            S_MIN, S_MONTH: bus.blink_mask = {1'b0, phase_q, 1'b0};
            S_DAY:          bus.blink_mask = {2'b00, phase_q};
            default:        bus.blink_mask = 3'b000;
        endcase
    end

    assign bus.set_active = is_set(state_q);
    assign bus.show_date  = (state_q == S_DAY) || (state_q == S_MONTH) || (state_q == S_YEAR);
    assign bus.load       = (state_q == S_COMMIT);
    assign bus.load_hour  = hour_q;
    assign bus.load_min   = min_q;
    assign bus.load_day   = day_load_q;
    assign bus.load_month = month_q;
    assign bus.load_year  = year_q;
    assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_time_set_controller.sv
module tb_time_set_controller;
  localparam logic [2:0] ST_RUN    = 3'd0;
  localparam logic [2:0] ST_HOUR   = 3'd1;
  localparam logic [2:0] ST_MIN    = 3'd2;
  localparam logic [2:0] ST_DAY    = 3'd3;
  localparam logic [2:0] ST_MONTH  = 3'd4;
  localparam logic [2:0] ST_YEAR   = 3'd5;
  localparam logic [2:0] ST_COMMIT = 3'd6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic [2:0] dbg_state;
  time_set_if bus();

  always #5 clk = ~clk;

  time_set_controller #(
    .DEBOUNCE_CYCLES(4),
    .BLINK_HALF_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [26:0] exp_q[$];
  logic [26:0] exp_load;
  logic [26:0] obs_load;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [26:0] pk(input int h, input int m, input int d, input int mo, input int y);
    return {5'(h), 6'(m), 5'(d), 4'(mo), 7'(y)};
  endfunction

  always @(negedge clk) begin
    if (reset === 1'b0 && bus.load === 1'b1) begin
      chk("load_expected", exp_q.size() > 0, 1);
      chk("load_state", dbg_state, ST_COMMIT);
      chk("load_set_active", bus.set_active, 0);
      if (exp_q.size() > 0) begin
        exp_load = exp_q.pop_front();
        obs_load = {bus.load_hour, bus.load_min, bus.load_day, bus.load_month, bus.load_year};
        chk("load_values", obs_load, exp_load);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_cur(input int h, input int m, input int d, input int mo, input int y);
    bus.cur_hour  = 5'(h);
    bus.cur_min   = 6'(m);
    bus.cur_day   = 5'(d);
    bus.cur_month = 4'(mo);
    bus.cur_year  = 7'(y);
  endtask

  task automatic push(input bit mode, input bit inc, input int hold);
    if (mode) bus.btn_mode_n = 1'b0;
    if (inc)  bus.btn_inc_n  = 1'b0;
    cycles(hold);
    bus.btn_mode_n = 1'b1;
    bus.btn_inc_n  = 1'b1;
    cycles(10);
  endtask

  task automatic press_mode();
    push(1'b1, 1'b0, 10);
  endtask

  task automatic press_inc();
    push(1'b0, 1'b1, 10);
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag);
    int n = 0;
    while (dbg_state !== s && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(tag, dbg_state, s);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    bus.btn_mode_n = 1'b1;
    bus.btn_inc_n  = 1'b1;
    set_cur(0, 0, 1, 1, 0);
    reset = 1'b1;
    cycles(3);
    chk("rst_state", dbg_state, ST_RUN);
    chk("rst_set_active", bus.set_active, 0);
    chk("rst_show_date", bus.show_date, 0);
    chk("rst_blink", bus.blink_mask, 0);
    chk("rst_load", bus.load, 0);
    chk("rst_load_hour", bus.load_hour, 0);
    chk("rst_load_day", bus.load_day, 0);
    chk("rst_load_year", bus.load_year, 0);
    reset = 1'b0;
    cycles(2);

    // Session 1: capture 23:59 31/12/99, hour wraps, commit.
    set_cur(23, 59, 31, 12, 99);
    press_mode();
    chk("s1_state_hour", dbg_state, ST_HOUR);
    chk("s1_set_active", bus.set_active, 1);
    chk("s1_show_date", bus.show_date, 0);
    chk("s1_cap_hour", bus.load_hour, 23);
    chk("s1_cap_min", bus.load_min, 59);
    press_inc();
    chk("s1_hour_wrap", bus.load_hour, 0);
    repeat (4) press_mode();
    chk("s1_state_year", dbg_state, ST_YEAR);
    chk("s1_show_date_year", bus.show_date, 1);
    exp_q.push_back(pk(0, 59, 31, 12, 99));
    press_mode();
    chk("s1_back_run", dbg_state, ST_RUN);
    chk("s1_run_inactive", bus.set_active, 0);
    chk("s1_load_seen", exp_q.size(), 0);

    // Session 2: glitch, blink, inc clears blink, simultaneous events, Feb clamp.
    set_cur(10, 20, 31, 2, 23);
    press_mode();
    chk("s2_cap_hour", bus.load_hour, 10);
    push(1'b0, 1'b1, 3);
    cycles(4);
    chk("s2_glitch_ignored", bus.load_hour, 10);
    push(1'b0, 1'b1, 6);
    chk("s2_one_inc", bus.load_hour, 11);

    bus.btn_mode_n = 1'b0;
    wait_state(ST_MIN, "s2_enter_min");
    chk("s2_blink_entry", bus.blink_mask, 3'b000);
    cycles(7);
    chk("s2_blink_still_off", bus.blink_mask, 3'b000);
    cycles(1);
    chk("s2_blink_on", bus.blink_mask, 3'b010);
    bus.btn_mode_n = 1'b1;
    cycles(7);
    chk("s2_blink_on_hold", bus.blink_mask, 3'b010);
    cycles(1);
    chk("s2_blink_off_again", bus.blink_mask, 3'b000);

    n = 0;
    while (bus.blink_mask !== 3'b010 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("s2_blink_rewait", bus.blink_mask, 3'b010);
    bus.btn_inc_n = 1'b0;
    n = 0;
    while (bus.load_min === 6'd20 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("s2_inc_min", bus.load_min, 21);
    chk("s2_inc_clears_blink", bus.blink_mask, 3'b000);
    bus.btn_inc_n = 1'b1;
    cycles(10);

    bus.btn_mode_n = 1'b0;
    bus.btn_inc_n  = 1'b0;
    wait_state(ST_DAY, "s2_simul_state");
    cycles(4);
    bus.btn_mode_n = 1'b1;
    bus.btn_inc_n  = 1'b1;
    cycles(10);
    chk("s2_simul_state_hold", dbg_state, ST_DAY);
    chk("s2_simul_min_unchanged", bus.load_min, 21);
    chk("s2_show_date_day", bus.show_date, 1);
    press_mode();
    press_mode();
    chk("s2_state_year", dbg_state, ST_YEAR);
    chk("s2_blink_year", bus.blink_mask, 3'b100);
    chk("s2_show_date_year", bus.show_date, 1);
    exp_q.push_back(pk(11, 21, 28, 2, 23));
    press_mode();
    chk("s2_back_run", dbg_state, ST_RUN);
    chk("s2_load_seen", exp_q.size(), 0);

    // Session 3: leap year reached by year increment -> day 29.
    set_cur(5, 5, 31, 2, 23);
    repeat (5) press_mode();
    press_inc();
    chk("s3_year_inc", bus.load_year, 24);
    exp_q.push_back(pk(5, 5, 29, 2, 24));
    press_mode();
    chk("s3_back_run", dbg_state, ST_RUN);
    chk("s3_load_seen", exp_q.size(), 0);

    // Session 4: day inc, month inc to April (clamp 30), year wrap 99 -> 0.
    set_cur(0, 0, 30, 3, 99);
    repeat (3) press_mode();
    press_inc();
    chk("s4_day_inc", bus.load_day, 31);
    press_mode();
    press_inc();
    chk("s4_month_inc", bus.load_month, 4);
    press_mode();
    press_inc();
    chk("s4_year_wrap", bus.load_year, 0);
    exp_q.push_back(pk(0, 0, 30, 4, 0));
    press_mode();
    chk("s4_back_run", dbg_state, ST_RUN);
    chk("s4_load_seen", exp_q.size(), 0);

    // Session 5: reset in SET_MONTH discards the edit.
    set_cur(7, 8, 9, 10, 11);
    repeat (4) press_mode();
    chk("s5_state_month", dbg_state, ST_MONTH);
    reset = 1'b1;
    cycles(1);
    chk("s5_rst_state", dbg_state, ST_RUN);
    chk("s5_rst_set_active", bus.set_active, 0);
    chk("s5_rst_show_date", bus.show_date, 0);
    chk("s5_rst_blink", bus.blink_mask, 0);
    chk("s5_rst_load_hour", bus.load_hour, 0);
    chk("s5_rst_load_month", bus.load_month, 0);
    reset = 1'b0;
    cycles(20);
    chk("s5_stay_run", dbg_state, ST_RUN);
    chk("s5_no_load", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
